// File: rtl/median_frame_serializer.sv
// ---------------------------------------------------------------------------
// median_frame_serializer
//
// Purpose:
//   Takes one completed frame from the median filter as a parallel bus and
//   streams it out one pixel per beat over a valid/ready interface. Pixels
//   leave in row-major order. Each beat carries start-of-frame, end-of-line
//   and end-of-frame flags. The whole frame is captured in a single cycle, so
//   the filter upstream can start on its next frame while this one drains.
//
// Parameters:
//   R_I  image rows    (>= 1)
//   C_I  image columns (>= 1)
//   W_I  bits per pixel
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (takes effect regardless of cen)
//   cen        clock enable; low freezes every register and every handshake
//   start      final_img holds a valid frame; capture request
//   s_ready    high while idle, i.e. start will be accepted
//   final_img  packed [R_I-1:0][C_I-1:0][W_I-1:0] input frame
//   m_valid    m_data and the flags carry a beat
//   m_ready    downstream accepts the current beat
//   m_data     pixel value
//   m_sof      beat is pixel [0][0]
//   m_eol      beat is the last column of a row
//   m_eof      beat is pixel [R_I-1][C_I-1]
//   busy       a frame is held and is being streamed
// ---------------------------------------------------------------------------
module median_frame_serializer #(
  parameter int R_I = 5,
  parameter int C_I = 5,
  parameter int W_I = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cen,
  input  logic                               start,
  output logic                               s_ready,
  input  logic [R_I-1:0][C_I-1:0][W_I-1:0]   final_img,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [W_I-1:0]                     m_data,
  output logic                               m_sof,
  output logic                               m_eol,
  output logic                               m_eof,
  output logic                               busy
);

  // Position counters need at least one bit, even for a single row/column.
  localparam int RW = (R_I > 1) ? $clog2(R_I) : 1;
  localparam int CW = (C_I > 1) ? $clog2(C_I) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(R_I - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(C_I - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  typedef logic [R_I-1:0][C_I-1:0][W_I-1:0] frame_t;

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] row_q,   row_d;
  logic [CW-1:0] col_q,   col_d;
  frame_t        frame_q, frame_d;

  logic at_row_last;
  logic at_col_last;

  assign at_row_last = (row_q == ROW_LAST);
  assign at_col_last = (col_q == COL_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    frame_d = frame_q;

    if (cen) begin
      unique case (state_q)
        ST_IDLE: begin
          // Capture the whole frame at once; later changes on final_img are
          // invisible to the stream that follows.
          if (start) begin
            frame_d = final_img;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_STREAM;
          end
        end

        ST_STREAM: begin
          // m_valid is always high here, so a transfer is simply m_ready.
          // start is deliberately not examined: requests while busy are
          // dropped, not queued.
          if (m_ready) begin
            if (at_col_last) begin
              col_d = '0;
              if (at_row_last) begin
                row_d   = '0;
                state_d = ST_IDLE;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // Reset wins over cen: the enable is folded into the next-state logic, so
  // a reset still lands while the block is otherwise frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the frame store is reset as well; it is only R_I*C_I*W_I flops
      // and a defined value keeps m_data deterministic after reset.
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      frame_q <= frame_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Everything below is a function of registered state only, so data and
  // flags hold steady through any m_ready stall.
  always_comb begin
    m_valid = (state_q == ST_STREAM);
    busy    = m_valid;
    s_ready = (state_q == ST_IDLE);
    m_data  = m_valid ? frame_q[row_q][col_q] : '0;
    m_sof   = m_valid && (row_q == '0) && (col_q == '0);
    m_eol   = m_valid && at_col_last;
    m_eof   = m_valid && at_row_last && at_col_last;
  end

endmodule

// File: tb/tb_median_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_median_frame_serializer
//
// Directed testbench for median_frame_serializer (5x5, 8-bit pixels).
// Inputs change 1 ns after a rising edge and outputs are sampled at the same
// point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_median_frame_serializer;

  localparam int R = 5;
  localparam int C = 5;
  localparam int W = 8;
  localparam int N = R * C;

  typedef logic [R-1:0][C-1:0][W-1:0] frame_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cen;
  logic         start;
  logic         s_ready;
  frame_t       final_img;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_sof;
  logic         m_eol;
  logic         m_eof;
  logic         busy;

  int checks = 0;
  int errors = 0;

  median_frame_serializer #(.R_I(R), .C_I(C), .W_I(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .start     (start),
    .s_ready   (s_ready),
    .final_img (final_img),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eol     (m_eol),
    .m_eof     (m_eof),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t ramp_frame(input int offset);
    frame_t f;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        f[r][c] = W'(r * 16 + c + offset);
    return f;
  endfunction

  // Expected beat word: {valid, sof, eol, eof, data} for beat k of frame f.
  function automatic logic [W+3:0] beat_word(input frame_t f, input int k);
    return {1'b1, 1'(k == 0), 1'(k % C == C - 1), 1'(k == N - 1), f[k / C][k % C]};
  endfunction

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; cen = 1'b1; start = 1'b0; m_ready = 1'b0; final_img = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({m_valid, m_sof, m_eol, m_eof, m_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v/sof/eol/eof/data=%b%b%b%b/%h want 0000/00",
               m_valid, m_sof, m_eol, m_eof, m_data);
    end
    checks++;
    if ({busy, s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_busy_ready: got busy=%b s_ready=%b want 0 1", busy, s_ready);
    end
  endtask

  // Ramp frame with m_ready always high: expected values written out by hand.
  task automatic test_ramp();
    logic [W-1:0] want_data;
    final_img = ramp_frame(0);
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= N; k++) begin
      want_data = W'(((k - 1) / 5) * 16 + (k - 1) % 5);
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !==
          {1'b1, 1'(k == 1), 1'(k % 5 == 0), 1'(k == 25), want_data}) begin
        errors++;
        $display("FAIL ramp_beat%0d: got v/sof/eol/eof/data=%b%b%b%b/%h want 1%b%b%b/%h",
                 k, m_valid, m_sof, m_eol, m_eof, m_data,
                 k == 1, k % 5 == 0, k == 25, want_data);
      end
      step();
    end
    checks++;
    if ({s_ready, m_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL ramp_end: got s_ready/m_valid/busy=%b%b%b want 100", s_ready, m_valid, busy);
    end
  endtask

  // m_ready toggles, with a 3-cycle hold-off on beat 7 (pixel 0x11).
  task automatic test_stall();
    frame_t exp_f = ramp_frame(0);
    int idx = 0, stall = 0, cyc = 0;
    final_img = exp_f;
    start     = 1'b1;
    step();
    start = 1'b0;
    while (idx < N && cyc < 200) begin
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !== beat_word(exp_f, idx)) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h want %h", idx + 1,
                 {m_valid, m_sof, m_eol, m_eof, m_data}, beat_word(exp_f, idx));
      end
      if (idx == 6 && stall < 3) begin
        m_ready = 1'b0;
        stall++;
      end else begin
        m_ready = (cyc % 2 == 0);
      end
      if (m_ready) idx++;
      cyc++;
      step();
    end
    m_ready = 1'b1;
    checks++;
    if (idx != N || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got beats=%0d s_ready=%b want %0d 1", idx, s_ready, N);
    end
  endtask

  // start re-pulsed mid-frame with a different final_img: must be ignored.
  task automatic test_restart_ignored();
    frame_t exp_f = ramp_frame(0);
    final_img = exp_f;
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 3) begin
        final_img = '1;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !== beat_word(exp_f, k)) begin
        errors++;
        $display("FAIL restart_beat%0d: got %h want %h", k + 1,
                 {m_valid, m_sof, m_eol, m_eof, m_data}, beat_word(exp_f, k));
      end
      step();
    end
    start = 1'b0;
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      errors++;
      $display("FAIL restart_end: got s_ready/m_valid=%b%b want 10", s_ready, m_valid);
    end
  endtask

  // cen low for 4 cycles at beat 9 with m_ready high: nothing may advance.
  task automatic test_cen();
    frame_t exp_f = ramp_frame(0);
    int idx = 0, frz = 0, cyc = 0;
    final_img = exp_f;
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    while (idx < N && cyc < 200) begin
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !== beat_word(exp_f, idx)) begin
        errors++;
        $display("FAIL cen_beat%0d: got %h want %h", idx + 1,
                 {m_valid, m_sof, m_eol, m_eof, m_data}, beat_word(exp_f, idx));
      end
      if (idx == 8 && frz < 4) begin
        cen = 1'b0;
        frz++;
      end else begin
        cen = 1'b1;
        idx++;
      end
      cyc++;
      step();
    end
    cen = 1'b1;
    checks++;
    if (idx != N || frz != 4 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL cen_done: got beats=%0d frozen=%0d s_ready=%b want %0d 4 1",
               idx, frz, s_ready, N);
    end
  endtask

  // Reset (with cen low) at beat 12, then a fresh frame from [0][0].
  task automatic test_mid_reset();
    frame_t exp_f = ramp_frame(8'h80);
    final_img = ramp_frame(0);
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 11; k++) step();
    rst = 1'b1;
    cen = 1'b0;
    step();
    rst = 1'b0;
    cen = 1'b1;
    checks++;
    if ({m_valid, busy, s_ready, m_sof, m_data} !== {4'b0010, 8'h00}) begin
      errors++;
      $display("FAIL midreset_state: got v/busy/rdy/sof/data=%b%b%b%b/%h want 0010/00",
               m_valid, busy, s_ready, m_sof, m_data);
    end
    final_img = exp_f;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !== beat_word(exp_f, k)) begin
        errors++;
        $display("FAIL midreset_beat%0d: got %h want %h", k + 1,
                 {m_valid, m_sof, m_eol, m_eof, m_data}, beat_word(exp_f, k));
      end
      step();
    end
  endtask

  // start held high across two random frames: one idle gap between them.
  task automatic test_back_to_back();
    frame_t exp_a, exp_b;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        exp_a[r][c] = W'($urandom_range(0, 255));
        exp_b[r][c] = W'($urandom_range(0, 255));
      end
    final_img = exp_a;
    m_ready   = 1'b1;
    start     = 1'b1;
    step();
    final_img = exp_b;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !== beat_word(exp_a, k)) begin
        errors++;
        $display("FAIL b2b_a_beat%0d: got %h want %h", k + 1,
                 {m_valid, m_sof, m_eol, m_eof, m_data}, beat_word(exp_a, k));
      end
      step();
    end
    checks++;
    if ({m_valid, s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: got m_valid/s_ready=%b%b want 01", m_valid, s_ready);
    end
    step();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({m_valid, m_sof, m_eol, m_eof, m_data} !== beat_word(exp_b, k)) begin
        errors++;
        $display("FAIL b2b_b_beat%0d: got %h want %h", k + 1,
                 {m_valid, m_sof, m_eol, m_eof, m_data}, beat_word(exp_b, k));
      end
      step();
    end
    checks++;
    if ({m_valid, s_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_end: got m_valid/s_ready/busy=%b%b%b want 010", m_valid, s_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_restart_ignored();
    test_cen();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
